vga_timing_checker: RTL and testbench

Receiving-end monitor for the VGA output stream: samples the sync and colour lines driven by the `vga` block on the same 25 MHz pixel clock. It measures line length, frame length and sync pulse widths, and checks them against 640x480@60 timing. It also computes a per-frame checksum of active-region pixels. It sits beside `vga` in `top` as a built-in self-test; `locked` and `error` drive the board LEDs.

---
 rtl/vga_timing_checker.sv | 193 +++++++++++++++++++
 tb/tb_vga_timing_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_checker.sv
// vga_timing_checker
//   Receiving-end monitor for a VGA sync/colour stream on the pixel clock.
//   It measures line length, frame length and sync widths and checks them
//   against the configured timing. It also keeps a per-frame sum of the
//   active-region pixels. The block is locked after a frame with clean
//   timing. A later bad frame, or a counter running away while locked,
//   sets a sticky error.
// Ports
//   clk, reset       pixel clock, synchronous active-high reset
//   hs, vs           sync inputs (asserted level = SYNC_POL)
//   r, g, b          4-bit colour inputs
//   h_count          last measured line length (clocks)
//   v_count          last measured frame length (lines)
//   checksum         active-pixel sum of the last complete frame, mod 2^16
//   frames           good-frame counter, wraps
//   frame_done       one-cycle pulse per completed frame while checking/locked
//   locked, error    timing verified / sticky loss-of-lock flag
module vga_timing_checker #(
  parameter int   H_TOTAL  = 800,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   V_TOTAL  = 525,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   V_ACTIVE = 480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic [15:0] checksum,
  output logic [7:0]  frames,
  output logic        frame_done,
  output logic        locked,
  output logic        error
);

  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
  localparam logic [9:0]  H_SW    = 10'(H_SYNC);
  localparam logic [9:0]  V_SW    = 10'(V_SYNC);
  localparam logic [9:0]  HA_LO   = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  HA_HI   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  VA_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VA_HI   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

  // One pixel after edge detection; every counter update works from this.
  typedef struct packed {
    logic        hs_a;
    logic        vs_a;
    logic        ls;   // line start
    logic        fs;   // frame start
    logic        he;   // hs deassert edge
    logic [11:0] rgb;
  } pix_t;

  logic        hs_a1, vs_a1;
  logic [11:0] rgb1;
  pix_t        s2;

  state_t      state, state_nxt;
  logic [9:0]  hcnt, vcnt, vsl;
  logic [9:0]  hcnt_inc, vcnt_inc, hcnt_nxt, vcnt_nxt;
  logic [10:0] h_len, v_len;
  logic [15:0] acc, pix_add;
  logic        frame_bad, line_bad_now, frame_good, active, sat;
  logic        done_nxt, frame_inc, set_err;

  // Stage 1: register and normalise the raw inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_a1 <= 1'b0;
      vs_a1 <= 1'b0;
      rgb1  <= '0;
    end else begin
      hs_a1 <= (hs == SYNC_POL);
      vs_a1 <= (vs == SYNC_POL);
      rgb1  <= {r, g, b};
    end
  end

  // Stage 2: edge flags aligned with the pixel they belong to.
  always_ff @(posedge clk) begin
    if (reset) s2 <= '0;
    else begin
      s2.hs_a <= hs_a1;
      s2.vs_a <= vs_a1;
      s2.ls   <= hs_a1 & ~s2.hs_a;
      s2.fs   <= vs_a1 & ~s2.vs_a;
      s2.he   <= ~hs_a1 & s2.hs_a;
      s2.rgb  <= rgb1;
    end
  end

  // hcnt/vcnt hold the index of the previous pixel; *_nxt is the index of
  // the pixel now in stage 2, so active-region and width checks use *_nxt.
  always_comb begin
    hcnt_inc = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 10'd1;
    vcnt_inc = (vcnt == CNT_MAX) ? CNT_MAX : vcnt + 10'd1;
    hcnt_nxt = s2.ls ? '0 : hcnt_inc;
    vcnt_nxt = s2.fs ? '0 : (s2.ls ? vcnt_inc : vcnt);
    h_len    = {1'b0, hcnt} + 11'd1;
    v_len    = {1'b0, vcnt} + 11'd1;
    active   = (hcnt_nxt >= HA_LO) && (hcnt_nxt <= HA_HI) &&
               (vcnt_nxt >= VA_LO) && (vcnt_nxt <= VA_HI);
    pix_add  = active ? {4'd0, s2.rgb} : 16'd0;
    // The line ending at a coincident frame start belongs to the old frame.
    line_bad_now = (s2.ls && (h_len != H_TOT)) || (s2.he && (hcnt_nxt != H_SW));
    frame_good   = (v_len == V_TOT) && (vsl == V_SW) && !frame_bad && !line_bad_now;
    sat          = (hcnt_nxt == CNT_MAX) || (vcnt_nxt == CNT_MAX);
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    frame_inc = 1'b0;
    set_err   = 1'b0;
    if (sat) begin
      // A runaway counter overrides any coincident frame start.
      state_nxt = UNLOCKED;
      set_err   = (state == LOCKED);
    end else if (s2.fs) begin
      case (state)
        UNLOCKED: state_nxt = CHECK;
        CHECK: begin
          done_nxt = 1'b1;
          if (frame_good) begin
            state_nxt = LOCKED;
            frame_inc = 1'b1;
          end
        end
        LOCKED: begin
          done_nxt = 1'b1;
          if (frame_good) frame_inc = 1'b1;
          else begin
            state_nxt = CHECK;
            set_err   = 1'b1;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNLOCKED;
      hcnt       <= '0;
      vcnt       <= '0;
      vsl        <= '0;
      frame_bad  <= 1'b0;
      acc        <= '0;
      h_count    <= '0;
      v_count    <= '0;
      checksum   <= '0;
      frames     <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      hcnt       <= hcnt_nxt;
      vcnt       <= vcnt_nxt;
      frame_done <= done_nxt;
      locked     <= (state_nxt == LOCKED);
      error      <= error | set_err;
      if (frame_inc) frames <= frames + 8'd1;
      if (s2.ls) h_count <= h_len[9:0];
      if (s2.fs) begin
        v_count   <= v_len[9:0];
        checksum  <= acc;
        acc       <= pix_add;
        frame_bad <= 1'b0;
        vsl       <= (s2.ls && s2.vs_a) ? 10'd1 : 10'd0;
      end else begin
        acc <= acc + pix_add;
        if (line_bad_now) frame_bad <= 1'b1;
        if (s2.ls && s2.vs_a && vsl != CNT_MAX) vsl <= vsl + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_checker.sv
// Scoreboard bench for vga_timing_checker on a scaled-down raster (40x20).
// The driver pushes the expected outputs at every line start (due two edges
// after the sampling edge), and the negedge monitor pops and compares them.
module tb_vga_timing_checker;
  localparam int H_TOTAL = 40, H_SYNC = 6, H_BP = 4, H_ACTIVE = 24;
  localparam int V_TOTAL = 20, V_SYNC = 2, V_BP = 3, V_ACTIVE = 12;
  localparam logic SYNC_POL = 1'b0;
  localparam int HA0 = H_SYNC + H_BP, HA1 = HA0 + H_ACTIVE - 1;
  localparam int VA0 = V_SYNC + V_BP, VA1 = VA0 + V_ACTIVE - 1;

  logic clk = 1'b0, reset = 1'b1, hs, vs;
  logic [3:0]  r, g, b;
  logic [9:0]  h_count, v_count;
  logic [15:0] checksum;
  logic [7:0]  frames;
  logic        frame_done, locked, error;

  vga_timing_checker #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE),
    .SYNC_POL(SYNC_POL)
  ) dut (
    .clk(clk), .reset(reset), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .h_count(h_count), .v_count(v_count), .checksum(checksum), .frames(frames),
    .frame_done(frame_done), .locked(locked), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          m_h, m_v, m_cs, m_st;
    logic [9:0]  h, v;
    logic [15:0] cs;
    logic [7:0]  fr;
    bit          lk, er, dn;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame-level reference model
  int          m_state;   // 0 unlocked, 1 check, 2 locked
  logic [7:0]  m_frames;
  bit          m_err, m_bad, m_fpart, m_lpart;
  logic [15:0] m_acc;
  int          m_nlines, m_prev_len, m_ls_edge;

  always @(negedge clk) begin : mon
    exp_t e;
    bit   st_seen;
    st_seen = 1'b0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.m_h)  chk("h_count", 32'(h_count), 32'(e.h));
      if (e.m_v)  chk("v_count", 32'(v_count), 32'(e.v));
      if (e.m_cs) chk("checksum", 32'(checksum), 32'(e.cs));
      if (e.m_st) begin
        st_seen = 1'b1;
        chk("frame_done", 32'(frame_done), 32'(e.dn));
        chk("locked", 32'(locked), 32'(e.lk));
        chk("error", 32'(error), 32'(e.er));
        chk("frames", 32'(frames), 32'(e.fr));
      end
    end
    if (!st_seen && frame_done) chk("spurious_done", 32'(frame_done), 32'd0);
  end

  task automatic on_line_start(input bit is_fs);
    exp_t e;
    bit   good;
    e = '{default: 0};
    e.due = cyc + 2;
    e.m_h = !m_lpart;
    e.h   = 10'(m_prev_len);
    m_ls_edge = cyc;
    m_lpart   = 1'b0;
    if (is_fs) begin
      good   = !m_bad && (m_nlines == V_TOTAL) && !m_fpart;
      e.m_v  = !m_fpart;
      e.m_cs = !m_fpart;
      e.v    = 10'(m_nlines);
      e.cs   = m_acc;
      e.m_st = 1'b1;
      case (m_state)
        0: m_state = 1;
        1: begin
          e.dn = 1'b1;
          if (good) begin m_state = 2; m_frames++; end
        end
        default: begin
          e.dn = 1'b1;
          if (good) m_frames++;
          else begin m_state = 1; m_err = 1'b1; end
        end
      endcase
      e.lk = (m_state == 2);
      e.er = m_err;
      e.fr = m_frames;
      m_acc = '0; m_bad = 1'b0; m_nlines = 0; m_fpart = 1'b0;
    end
    m_nlines++;
    sb.push_back(e);
  endtask

  // pat: 0 zero, 1 all-F, 2 only first active pixel = 123, 3 random everywhere
  task automatic send_line(input int len, input int hsw, input int vidx, input int pat);
    logic [11:0] pix;
    bit          act;
    for (int i = 0; i < len; i++) begin
      act = (i >= HA0) && (i <= HA1) && (vidx >= VA0) && (vidx <= VA1);
      case (pat)
        0:       pix = 12'h000;
        1:       pix = 12'hfff;
        2:       pix = (i == HA0 && vidx == VA0) ? 12'h123 : 12'h000;
        default: pix = 12'($urandom_range(4095));
      endcase
      hs = (i < hsw) ? SYNC_POL : ~SYNC_POL;
      vs = (vidx < V_SYNC) ? SYNC_POL : ~SYNC_POL;
      {r, g, b} = pix;
      @(posedge clk); #1;
      if (i == 0) on_line_start(vidx == 0);
      if (act) m_acc = m_acc + {4'd0, pix};
    end
    if (len != H_TOTAL || hsw != H_SYNC) m_bad = 1'b1;
    m_prev_len = len;
  endtask

  task automatic send_frame(input int pat, input int bad_len, input int bad_hs,
                            input int first, input int last);
    for (int v = first; v <= last; v++)
      send_line((v == bad_len) ? H_TOTAL - 1 : H_TOTAL,
                (v == bad_hs) ? H_SYNC - 1 : H_SYNC, v, pat);
  endtask

  // Hold both syncs deasserted; hcnt runs into saturation 1023 pixels after
  // the last line start.
  task automatic hold_sync(input int n);
    exp_t e;
    hs = ~SYNC_POL; vs = ~SYNC_POL; {r, g, b} = 12'h000;
    e = '{default: 0};
    e.m_st = 1'b1;
    e.due  = m_ls_edge + 1024;
    e.lk   = (m_state == 2);
    e.er   = m_err;
    e.fr   = m_frames;
    sb.push_back(e);
    if (m_state == 2) m_err = 1'b1;
    m_state = 0;
    e.due++;
    e.lk = 1'b0;
    e.er = m_err;
    sb.push_back(e);
    m_fpart = 1'b1; m_lpart = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    sb.delete();
    reset = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
    m_state = 0; m_frames = '0; m_err = 1'b0; m_acc = '0; m_bad = 1'b0;
    m_fpart = 1'b1; m_lpart = 1'b1; m_nlines = 1;
    chk("rst_h_count", 32'(h_count), 32'd0);
    chk("rst_v_count", 32'(v_count), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_frames", 32'(frames), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
  endtask

  initial begin
    hs = ~SYNC_POL; vs = ~SYNC_POL; {r, g, b} = 12'h000;
    m_prev_len = 0; m_ls_edge = 0;
    do_reset(3);
    send_frame(1, -1, -1, 0, V_TOTAL - 1);   // all-F frames, lock on 2nd start
    send_frame(1, -1, -1, 0, V_TOTAL - 1);
    send_frame(2, -1, -1, 0, V_TOTAL - 1);   // single 12'h123 pixel
    send_frame(3, -1, -1, 0, V_TOTAL - 1);   // random, blanking not summed
    send_frame(3,  7, -1, 0, V_TOTAL - 1);   // one short line
    send_frame(0, -1, -1, 0, V_TOTAL - 1);   // relock, error stays
    send_frame(1, -1, -1, 0, V_TOTAL - 1);
    send_frame(3, -1,  4, 0, V_TOTAL - 1);   // one short hs pulse
    send_frame(3, -1, -1, 0, V_TOTAL - 1);
    send_frame(3, -1, -1, 0, V_TOTAL - 1);
    send_frame(3, -1, -1, 0, 3);             // partial frame, then runaway hcnt
    hold_sync(1100);
    send_frame(3, -1, -1, 0, V_TOTAL - 1);
    send_frame(3, -1, -1, 0, V_TOTAL - 1);
    send_frame(3, -1, -1, 0, 8);             // reset mid-frame
    do_reset(2);
    send_frame(3, -1, -1, 9, V_TOTAL - 1);
    send_frame(3, -1, -1, 0, V_TOTAL - 1);
    send_frame(1, -1, -1, 0, V_TOTAL - 1);
    send_frame(0, -1, -1, 0, 0);             // closing frame start
    repeat (4) begin @(posedge clk); #1; end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
